// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues single-cycle imem requests from the IF PC,
// registers the returned word for ID, and converts misalignment/bus error/timeout into a NOP plus cause.
module if_fetch_ctrl #(
   parameter int          TIMEOUT   = 16,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pc_i,
   input  logic        mis_addr_exc_i,
   input  logic        branch_taken_i,
   input  logic        pipe_stall_i,
   input  logic        imem_ack_i,
   input  logic        imem_err_i,
   input  logic [31:0] imem_rdata_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   output logic        if_stall_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        instr_valid_o,
   output logic [1:0]  exc_o,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_nxt;
   logic        w_accept;
   logic        w_req;
   logic        w_consume;
   logic        w_exc;
   logic [1:0]  w_exc_code;

   // Handshake: a word transfers on any cycle with imem_req_o & imem_ack_i & !imem_err_i;
   // the ID side takes instr_o on any cycle with instr_valid_o & !pipe_stall_i.
   assign w_accept = !instr_valid_o | !pipe_stall_i;

   always_comb begin
      w_next     = r_state;
      w_req      = 1'b0;
      w_exc      = 1'b0;
      w_exc_code = 2'b00;
      case (r_state)
         S_IDLE:  w_next = S_FETCH;
         S_FETCH: begin
            w_req = w_accept & !branch_taken_i & !mis_addr_exc_i;
            if (w_accept && !branch_taken_i) begin
               if (mis_addr_exc_i) begin
                  w_exc      = 1'b1;
                  w_exc_code = 2'b01;
               end else if (imem_err_i) begin
                  w_exc      = 1'b1;
                  w_exc_code = 2'b10;
               end else if (!imem_ack_i && r_cnt == LP_TMO_LAST) begin
                  w_exc      = 1'b1;
                  w_exc_code = 2'b11;
               end
            end
            if (w_exc) w_next = S_HALT;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_IDLE;
      endcase
      if (branch_taken_i) w_next = S_FETCH;
   end

   assign w_consume   = w_req & imem_ack_i & !imem_err_i;
   assign imem_req_o  = w_req;
   assign imem_addr_o = pc_i;
   assign if_stall_o  = !(branch_taken_i | w_consume);
   assign dbg_state_o = r_state;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (branch_taken_i || !w_req || w_consume) begin
         w_cnt_nxt = 8'd0;
      end else if (!imem_ack_i && !imem_err_i && r_cnt != 8'hFF) begin
         w_cnt_nxt = r_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= S_IDLE;
         r_cnt         <= 8'd0;
         instr_o       <= NOP_INSTR;
         instr_pc_o    <= 32'd0;
         instr_valid_o <= 1'b0;
         exc_o         <= 2'b00;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         // A redirect flushes the output stage even when ID is stalled.
         if (branch_taken_i) begin
            instr_valid_o <= 1'b0;
            exc_o         <= 2'b00;
         end else if (w_consume) begin
            instr_o       <= imem_rdata_i;
            instr_pc_o    <= pc_i;
            exc_o         <= 2'b00;
            instr_valid_o <= 1'b1;
         end else if (w_exc) begin
            instr_o       <= NOP_INSTR;
            instr_pc_o    <= pc_i;
            exc_o         <= w_exc_code;
            instr_valid_o <= 1'b1;
         end else if (!pipe_stall_i) begin
            instr_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with TIMEOUT = 4; expected values are hand-derived per scenario.
module tb_if_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        mis;
   logic        br;
   logic        ps;
   logic        ack;
   logic        err;
   logic [31:0] rdata;
   logic        req;
   logic [31:0] addr;
   logic        stall;
   logic [31:0] instr;
   logic [31:0] ipc;
   logic        vld;
   logic [1:0]  exc;
   logic [1:0]  dbg;

   int checks = 0;
   int errors = 0;

   if_fetch_ctrl #(.TIMEOUT(4), .NOP_INSTR(NOP)) dut (
      .clk_i(clk), .rst_i(rst), .pc_i(pc), .mis_addr_exc_i(mis),
      .branch_taken_i(br), .pipe_stall_i(ps), .imem_ack_i(ack),
      .imem_err_i(err), .imem_rdata_i(rdata), .imem_req_o(req),
      .imem_addr_o(addr), .if_stall_o(stall), .instr_o(instr),
      .instr_pc_o(ipc), .instr_valid_o(vld), .exc_o(exc), .dbg_state_o(dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic [31:0] p, input logic m, input logic b, input logic s,
                        input logic a, input logic e, input logic [31:0] d);
      @(negedge clk);
      pc = p; mis = m; br = b; ps = s; ack = a; err = e; rdata = d;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(32'h0, 0, 0, 0, 0, 0, 32'h0);
      checks++;
      if ({instr, ipc, vld, exc} !== {NOP, 32'h0, 1'b0, 2'b00}) begin
         errors++;
         $display("FAIL reset_regs: instr=%h pc=%h vld=%b exc=%b want %h 0 0 00", instr, ipc, vld, exc, NOP);
      end
      checks++;
      if ({req, stall} !== 2'b01) begin
         errors++;
         $display("FAIL reset_comb: req/stall=%b%b want 01", req, stall);
      end
   endtask

   task automatic test_first_fetch();
      @(negedge clk);
      rst = 1'b0; pc = 32'h0; ack = 1'b1; rdata = 32'h00500093;
      #1;
      checks++;
      if ({req, stall} !== 2'b01) begin
         errors++;
         $display("FAIL idle_cycle: req/stall=%b%b want 01", req, stall);
      end
      drive(32'h0, 0, 0, 0, 1, 0, 32'h00500093);
      checks++;
      if ({req, stall, addr} !== {2'b10, 32'h0}) begin
         errors++;
         $display("FAIL first_req: req/stall=%b%b addr=%h want 10 0", req, stall, addr);
      end
      tick();
      checks++;
      if ({instr, ipc, vld, exc} !== {32'h00500093, 32'h0, 1'b1, 2'b00}) begin
         errors++;
         $display("FAIL first_data: instr=%h pc=%h vld=%b exc=%b want 00500093 0 1 00", instr, ipc, vld, exc);
      end
   endtask

   task automatic test_pipe_stall();
      for (int i = 0; i < 3; i++) begin
         drive(32'h4, 0, 0, 1, 1, 0, 32'hAAAA0001);
         checks++;
         if ({req, stall} !== 2'b01) begin
            errors++;
            $display("FAIL stall_comb[%0d]: req/stall=%b%b want 01", i, req, stall);
         end
         tick();
         checks++;
         if ({instr, ipc, vld, exc} !== {32'h00500093, 32'h0, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: instr=%h pc=%h vld=%b exc=%b want 00500093 0 1 00", i, instr, ipc, vld, exc);
         end
      end
      drive(32'h4, 0, 0, 0, 1, 0, 32'hAAAA0001);
      checks++;
      if ({req, stall} !== 2'b10) begin
         errors++;
         $display("FAIL resume_comb: req/stall=%b%b want 10", req, stall);
      end
      tick();
      checks++;
      if ({instr, ipc, vld} !== {32'hAAAA0001, 32'h4, 1'b1}) begin
         errors++;
         $display("FAIL resume_data: instr=%h pc=%h vld=%b want aaaa0001 4 1", instr, ipc, vld);
      end
   endtask

   task automatic test_misaligned();
      drive(32'h102, 1, 0, 0, 1, 0, 32'hBBBB0000);
      checks++;
      if ({req, stall} !== 2'b01) begin
         errors++;
         $display("FAIL mis_comb: req/stall=%b%b want 01", req, stall);
      end
      tick();
      checks++;
      if ({instr, ipc, vld, exc} !== {NOP, 32'h102, 1'b1, 2'b01}) begin
         errors++;
         $display("FAIL mis_exc: instr=%h pc=%h vld=%b exc=%b want 00000013 102 1 01", instr, ipc, vld, exc);
      end
      drive(32'h104, 0, 0, 0, 1, 0, 32'hBBBB0000);
      checks++;
      if ({req, stall} !== 2'b01) begin
         errors++;
         $display("FAIL halt_comb: req/stall=%b%b want 01", req, stall);
      end
      tick();
      checks++;
      if (vld !== 1'b0) begin
         errors++;
         $display("FAIL halt_drain: vld=%b want 0", vld);
      end
      drive(32'h200, 0, 1, 0, 1, 0, 32'hBBBB0000);
      checks++;
      if ({req, stall} !== 2'b00) begin
         errors++;
         $display("FAIL halt_branch_comb: req/stall=%b%b want 00", req, stall);
      end
      tick();
      checks++;
      if ({vld, exc} !== 3'b000) begin
         errors++;
         $display("FAIL halt_branch_regs: vld=%b exc=%b want 0 00", vld, exc);
      end
      drive(32'h200, 0, 0, 0, 1, 0, 32'hCCCC0002);
      tick();
      checks++;
      if ({instr, ipc, vld, exc} !== {32'hCCCC0002, 32'h200, 1'b1, 2'b00}) begin
         errors++;
         $display("FAIL mis_resume: instr=%h pc=%h vld=%b exc=%b want cccc0002 200 1 00", instr, ipc, vld, exc);
      end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 4; i++) begin
         drive(32'h300, 0, 0, 0, 0, 0, 32'hEEEE0000);
         checks++;
         if ({req, stall} !== 2'b11) begin
            errors++;
            $display("FAIL tmo_req[%0d]: req/stall=%b%b want 11", i, req, stall);
         end
         tick();
         if (i < 3) begin
            checks++;
            if ({vld, exc} !== 3'b000) begin
               errors++;
               $display("FAIL tmo_early[%0d]: vld=%b exc=%b want 0 00", i, vld, exc);
            end
         end
      end
      checks++;
      if ({instr, ipc, vld, exc} !== {NOP, 32'h300, 1'b1, 2'b11}) begin
         errors++;
         $display("FAIL tmo_exc: instr=%h pc=%h vld=%b exc=%b want 00000013 300 1 11", instr, ipc, vld, exc);
      end
      drive(32'h300, 0, 0, 0, 1, 0, 32'hEEEE0000);
      checks++;
      if (req !== 1'b0) begin
         errors++;
         $display("FAIL tmo_halt: req=%b want 0", req);
      end
      tick();
   endtask

   task automatic test_bus_error();
      drive(32'h400, 0, 1, 0, 0, 0, 32'h0);
      tick();
      drive(32'h400, 0, 0, 0, 1, 1, 32'hDEADBEEF);
      checks++;
      if ({req, stall} !== 2'b11) begin
         errors++;
         $display("FAIL err_comb: req/stall=%b%b want 11", req, stall);
      end
      tick();
      checks++;
      if ({instr, ipc, vld, exc} !== {NOP, 32'h400, 1'b1, 2'b10}) begin
         errors++;
         $display("FAIL err_exc: instr=%h pc=%h vld=%b exc=%b want 00000013 400 1 10", instr, ipc, vld, exc);
      end
      drive(32'h500, 0, 1, 0, 0, 0, 32'h0);
      tick();
   endtask

   task automatic test_branch_ack();
      drive(32'h500, 0, 0, 0, 1, 0, 32'h11110000);
      tick();
      checks++;
      if ({instr, ipc, vld} !== {32'h11110000, 32'h500, 1'b1}) begin
         errors++;
         $display("FAIL pre_branch: instr=%h pc=%h vld=%b want 11110000 500 1", instr, ipc, vld);
      end
      drive(32'h504, 0, 1, 1, 1, 0, 32'h22220000);
      checks++;
      if ({req, stall} !== 2'b00) begin
         errors++;
         $display("FAIL br_ack_comb: req/stall=%b%b want 00", req, stall);
      end
      tick();
      checks++;
      if ({instr, ipc, vld} !== {32'h11110000, 32'h500, 1'b0}) begin
         errors++;
         $display("FAIL br_ack_regs: instr=%h pc=%h vld=%b want 11110000 500 0", instr, ipc, vld);
      end
   endtask

   task automatic test_reset_mid_wait();
      drive(32'h600, 0, 0, 0, 0, 0, 32'h0);
      tick();
      drive(32'h600, 0, 0, 0, 0, 0, 32'h0);
      tick();
      drive(32'h600, 0, 0, 0, 0, 0, 32'h0);
      checks++;
      if (req !== 1'b1) begin
         errors++;
         $display("FAIL wait_req: req=%b want 1", req);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({req, stall, instr, ipc, vld, exc} !== {2'b01, NOP, 32'h0, 1'b0, 2'b00}) begin
         errors++;
         $display("FAIL async_rst: req/stall=%b%b instr=%h pc=%h vld=%b exc=%b want 01 00000013 0 0 00",
                  req, stall, instr, ipc, vld, exc);
      end
      tick();
      @(negedge clk);
      rst = 1'b0;
      #1;
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(32'h700, 0, 0, 0, 0, 0, 32'h0);
         tick();
         if (i < 3) begin
            checks++;
            if (exc !== 2'b00) begin
               errors++;
               $display("FAIL post_rst_cnt[%0d]: exc=%b want 00", i, exc);
            end
         end
      end
      checks++;
      if ({vld, exc} !== 3'b111) begin
         errors++;
         $display("FAIL post_rst_tmo: vld=%b exc=%b want 1 11", vld, exc);
      end
   endtask

   initial begin
      rst = 1'b1; pc = 32'h0; mis = 1'b0; br = 1'b0; ps = 1'b0;
      ack = 1'b0; err = 1'b0; rdata = 32'h0;
      test_reset();
      test_first_fetch();
      test_pipe_stall();
      test_misaligned();
      test_timeout();
      test_bus_error();
      test_branch_ack();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
